// File: rtl/timer_peripheral_pkg.sv
// Shared constants for the memory-mapped timer peripheral: register map,
// TCON bit positions, reset value, bus-control encodings and address decode.
package timer_peripheral_pkg;

  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_LED     = 8'h0C;
  localparam logic [7:0] OFF_SYSTICK = 8'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  localparam logic [31:0] REG_RESET = 32'h0000_0000;

  // MEM-stage control pair as seen by the peripheral: {MemWrite, MemRead}.
  typedef enum logic [1:0] {
    MEM_IDLE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_BOTH  = 2'b11
  } mem_op_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_SYSTICK
  } reg_sel_e;

  function automatic logic [31:0] word_of(input logic [31:0] base, input logic [7:0] off);
    return (base + {24'h0, off}) & 32'hFFFF_FFFC;
  endfunction

  // word_addr must already have its two byte-select bits cleared.
  function automatic reg_sel_e decode(input logic [31:0] word_addr, input logic [31:0] base);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (word_addr == word_of(base, OFF_TH))           sel = SEL_TH;
    else if (word_addr == word_of(base, OFF_TL))      sel = SEL_TL;
    else if (word_addr == word_of(base, OFF_TCON))    sel = SEL_TCON;
    else if (word_addr == word_of(base, OFF_LED))     sel = SEL_LED;
    else if (word_addr == word_of(base, OFF_SYSTICK)) sel = SEL_SYSTICK;
    return sel;
  endfunction

endpackage

// File: rtl/timer_peripheral_core.sv
// Reload counter: TL counts up while enabled, reloads from TH on all-ones
// and latches the interrupt status bit on that reload.
module timer_core
  import timer_peripheral_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        status_we,
  input  logic        status_wdata,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic        status
);

  logic overflow;

  assign overflow = enable && (tl == 32'hFFFF_FFFF);

  // CPU writes to TL beat the count; an overflow beats a CPU clear of status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th     <= REG_RESET;
      tl     <= REG_RESET;
      status <= 1'b0;
    end else begin
      if (th_we) th <= wdata;

      if (tl_we)         tl <= wdata;
      else if (overflow) tl <= th;
      else if (enable)   tl <= tl + 32'd1;

      if (overflow)       status <= 1'b1;
      else if (status_we) status <= status_wdata;
    end
  end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped timer peripheral: address decode, TCON control bits, LED
// register, free-running SYSTICK and the registered load-data path.
module timer_peripheral
  import timer_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_WIDTH = 8
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [31:0]          Address,
  input  logic [31:0]          Write_data,
  output logic [31:0]          Read_data,
  output logic                 irq,
  output logic [LED_WIDTH-1:0] led
);

  mem_op_e     op;
  reg_sel_e    sel;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] word_addr;
  logic [1:0]  tcon_lo;
  logic [31:0] systick;
  logic [31:0] th;
  logic [31:0] tl;
  logic        status;
  logic [2:0]  tcon;
  logic [31:0] rd_mux;

  assign op        = mem_op_e'({MemWrite, MemRead});
  assign rd_en     = (op == MEM_LOAD)  || (op == MEM_BOTH);
  assign wr_en     = (op == MEM_STORE) || (op == MEM_BOTH);
  assign word_addr = Address & 32'hFFFF_FFFC;
  assign sel       = decode(word_addr, BASE_ADDR);
  assign tcon      = {status, tcon_lo};
  assign irq       = tcon_lo[TCON_IE] & status;

  timer_core u_core (
    .clk          (clk),
    .reset        (reset),
    .enable       (tcon_lo[TCON_EN]),
    .th_we        (wr_en && (sel == SEL_TH)),
    .tl_we        (wr_en && (sel == SEL_TL)),
    .status_we    (wr_en && (sel == SEL_TCON)),
    .status_wdata (Write_data[TCON_IS]),
    .wdata        (Write_data),
    .th           (th),
    .tl           (tl),
    .status       (status)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcon_lo <= 2'b00;
      led     <= '0;
      systick <= REG_RESET;
    end else begin
      systick <= systick + 32'd1;
      if (wr_en && (sel == SEL_TCON)) tcon_lo <= Write_data[1:0];
      if (wr_en && (sel == SEL_LED))  led     <= Write_data[LED_WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (sel)
      SEL_TH:      rd_mux = th;
      SEL_TL:      rd_mux = tl;
      SEL_TCON:    rd_mux[2:0] = tcon;
      SEL_LED:     rd_mux[LED_WIDTH-1:0] = led;
      SEL_SYSTICK: rd_mux = systick;
      default:     rd_mux = '0;
    endcase
  end

  // Loads see the values held before this edge's updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      Read_data <= REG_RESET;
    else if (rd_en) Read_data <= rd_mux;
    else            Read_data <= REG_RESET;
  end

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed self-checking bench for timer_peripheral with hand-computed
// expectations and a small SYSTICK reference counter.
module tb_timer_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        irq;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;
  logic [31:0] tick_model = 32'h0;

  timer_peripheral #(.BASE_ADDR(BASE), .LED_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .irq        (irq),
    .led        (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) tick_model <= 32'h0;
    else       tick_model <= tick_model + 32'd1;
  end

  task automatic apply_stimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    MemRead    = rd;
    MemWrite   = wr;
    Address    = addr;
    Write_data = data;
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Address = 32'h0; Write_data = 32'h0;
    #1 reset = 1'b1;
    #2;
    check_output("reset_led",  {24'h0, led}, 32'h0);
    check_output("reset_rdata", Read_data, 32'h0);
    check_output("reset_irq",  {31'h0, irq}, 32'h0);
    #9 reset = 1'b0;

    // Reload sequence: TL counts to all-ones then reloads from TH.
    apply_stimulus(1'b0, 1'b1, BASE + 32'h00, 32'hFFFF_FFFC);
    apply_stimulus(1'b0, 1'b1, BASE + 32'h04, 32'hFFFF_FFFE);
    apply_stimulus(1'b0, 1'b1, BASE + 32'h08, 32'h3);
    apply_stimulus(1'b0, 1'b0, BASE, 32'h0);
    check_output("irq_before_reload", {31'h0, irq}, 32'h0);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h04, 32'h0);
    check_output("tl_allones", Read_data, 32'hFFFF_FFFF);
    check_output("irq_after_reload", {31'h0, irq}, 32'h1);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h04, 32'h0);
    check_output("tl_reloaded", Read_data, 32'hFFFF_FFFC);

    // Clear status, then try clearing it on the overflow edge.
    apply_stimulus(1'b0, 1'b1, BASE + 32'h08, 32'h3);
    check_output("irq_cleared", {31'h0, irq}, 32'h0);
    apply_stimulus(1'b0, 1'b0, BASE, 32'h0);
    check_output("irq_still_low", {31'h0, irq}, 32'h0);
    apply_stimulus(1'b0, 1'b1, BASE + 32'h08, 32'h3);
    check_output("irq_overflow_wins", {31'h0, irq}, 32'h1);

    // TL write priority over counting and one-cycle read latency.
    apply_stimulus(1'b0, 1'b1, BASE + 32'h08, 32'h1);
    apply_stimulus(1'b0, 1'b1, BASE + 32'h04, 32'h5);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h04, 32'h0);
    check_output("tl_written", Read_data, 32'h5);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h04, 32'h0);
    check_output("tl_plus_one", Read_data, 32'h6);
    apply_stimulus(1'b0, 1'b1, BASE + 32'h00, 32'd50);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h04, 32'h0);
    check_output("th_write_no_load", Read_data, 32'h8);
    apply_stimulus(1'b1, 1'b1, BASE + 32'h04, 32'd100);
    check_output("rw_old_value", Read_data, 32'h9);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h04, 32'h0);
    check_output("rw_new_value", Read_data, 32'd100);
    apply_stimulus(1'b0, 1'b0, BASE, 32'h0);
    check_output("rdata_idle_zero", Read_data, 32'h0);

    // Unmapped and out-of-window accesses.
    apply_stimulus(1'b1, 1'b0, BASE + 32'h10, 32'h0);
    check_output("unmapped_10", Read_data, 32'h0);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h20, 32'h0);
    check_output("unmapped_20", Read_data, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h5000_0014, 32'h0);
    check_output("other_window", Read_data, 32'h0);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h14, 32'h0);
    check_output("systick_a", Read_data, tick_model - 32'd1);
    apply_stimulus(1'b0, 1'b1, BASE + 32'h14, 32'd1234);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h14, 32'h0);
    check_output("systick_ro", Read_data, tick_model - 32'd1);

    // LED register, then an asynchronous reset between clock edges.
    apply_stimulus(1'b0, 1'b1, BASE + 32'h0C, 32'hFFFF_FFA5);
    check_output("led_value", {24'h0, led}, 32'hA5);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h0C, 32'h0);
    check_output("led_read", Read_data, 32'hA5);
    #1 reset = 1'b1;
    #1;
    check_output("async_led",   {24'h0, led}, 32'h0);
    check_output("async_rdata", Read_data, 32'h0);
    check_output("async_tl",    dut.u_core.tl, 32'h0);
    check_output("async_tick",  dut.systick, 32'h0);
    check_output("async_irq",   {31'h0, irq}, 32'h0);
    #1 reset = 1'b0;

    // After reset the timer must stay idle until enabled again.
    apply_stimulus(1'b0, 1'b0, BASE, 32'h0);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h04, 32'h0);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h04, 32'h0);
    check_output("tl_idle_after_reset", Read_data, 32'h0);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h08, 32'h0);
    check_output("tcon_after_reset", Read_data, 32'h0);

    // Overflow with interrupts disabled, then enable them.
    apply_stimulus(1'b0, 1'b1, BASE + 32'h04, 32'hFFFF_FFFE);
    apply_stimulus(1'b0, 1'b1, BASE + 32'h08, 32'h1);
    apply_stimulus(1'b0, 1'b0, BASE, 32'h0);
    apply_stimulus(1'b0, 1'b0, BASE, 32'h0);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h08, 32'h0);
    check_output("tcon_status_set", Read_data, 32'h5);
    check_output("irq_masked", {31'h0, irq}, 32'h0);
    apply_stimulus(1'b0, 1'b1, BASE + 32'h08, 32'h7);
    check_output("irq_unmasked", {31'h0, irq}, 32'h1);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h04, 32'h0);
    check_output("tl_reload_zero", Read_data, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
